blkmov_seq: RTL and testbench
=============================

# blkmov_seq

Block-move sequencer for the main bus: copies `len` bytes from the address held in SI to the address held in DI, one byte per read/write pair. Acts as the controller end of the 16-bit up/down/load pointer registers: it drives their active-high, single-cycle step strobes and never loads them; pointer loading stays with the microcode. Memory access uses a req/ack handshake toward the bus arbiter.

## Interface
- `CNT_W`, 16: width of the length and remaining-count datapath.
- `clk`  in  1  system clock, all state changes on rising edge.
- `clear_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a move; sampled only in IDLE.
- `dir`  in  1  0 = ascending (inc strobes), 1 = descending (dec strobes); latched at start.
- `len`  in  CNT_W  byte count; latched at start.
- `abort`  in  1  cancel the move in progress.
- `rd_req` / `rd_ack`  out / in  1  read handshake.
- `rd_data`  in  8  read byte, valid while `rd_ack` is high.
- `wr_req` / `wr_ack`  out / in  1  write handshake.
- `wr_data`  out  8  byte being written.
- `si_inc`, `si_dec`, `di_inc`, `di_dec`  out  1  one-cycle pointer step strobes.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a move completes normally.
- `remaining`  out  CNT_W  bytes still to move.
- `fill`, `fill_byte`  in  1, 8  present only with `BLKMOV_FILL_EN`.

## Operation
- States: IDLE, READ, WRITE, STEP, DONE.
- IDLE:
  - On `start`, latch `len` into `remaining` and latch `dir`.
  - If `len` = 0, go to DONE; otherwise go to READ.
- READ:
  - Hold `rd_req` high.
  - On the cycle `rd_ack` is high, capture `rd_data` into the byte latch and go to WRITE.
- WRITE:
  - Hold `wr_req` high with `wr_data` = byte latch, stable until acked.
  - On `wr_ack`, go to STEP.
- STEP:
  - Assert exactly one SI strobe and one DI strobe for one cycle: `*_inc` when `dir` = 0, `*_dec` when `dir` = 1.
  - Decrement `remaining`.
  - If the pre-decrement value was 1, go to DONE; otherwise go to READ.
- DONE: pulse `done` for one cycle, then return to IDLE.
- `start` while busy: ignored. `len`/`dir` changes mid-move: ignored.
- `abort` in any non-IDLE state:
  - Next state is IDLE.
  - No strobe, `done` or request is asserted in the abort cycle's successor.
  - `remaining` keeps its value, so software can compute progress.
- `abort` has priority over an ack arriving in the same cycle. That byte is not counted and no strobe is issued.
- Pointer wrap-around is the registers' business. This block only strobes.
- Never assert inc and dec together. Never assert a strobe outside STEP.
- `remaining` arithmetic is modulo 2^CNT_W. It never underflows because 0 is trapped in IDLE.

## Timing
- Reset values: state IDLE; all of `rd_req`, `wr_req`, the four strobes, `busy` and `done` = 0; `remaining` = 0; `wr_data` = 0.
- Acks are sampled in the same cycle as the req. A zero-wait ack costs one cycle per phase.
- Minimum per byte is 3 cycles (READ, WRITE, STEP). An N-byte zero-wait move has `busy` high for 3N+1 cycles; `done` is in the last of those cycles.
- `len` = 0: `busy` is high for 1 cycle (DONE), `done` pulses, and there are no bus requests.
- Acks in states that do not expect them are ignored.
- `clear_n` low mid-move: immediately returns to reset values and drops requests asynchronously.

## Configuration
- `BLKMOV_FILL_EN` defined:
  - Adds the `fill` and `fill_byte` ports.
  - When `fill` is high at start, READ is skipped: IDLE goes to WRITE, and STEP goes to WRITE.
  - `wr_data` = latched `fill_byte`.
  - Only the DI strobes fire; the SI strobes stay 0.
  - Zero-wait cost is 2 cycles per byte.
- `BLKMOV_FILL_EN` undefined: no fill ports; behaviour is copy only, as above.

## Test plan
- Reset with `clear_n` low mid-WRITE → `wr_req` drops with no clock edge; all outputs at reset values; `remaining` = 0.
- `len` = 3, `dir` = 0, zero-wait acks, read bytes 0x11/0x22/0x33 → writes 0x11/0x22/0x33 in order; 3 `si_inc` and 3 `di_inc` pulses; no dec strobes; `done` in cycle 10 after start; `remaining` = 0.
- `len` = 2, `dir` = 1, `rd_ack` delayed 4 cycles per read → only `si_dec`/`di_dec` fire; `rd_req` held stable through the wait; `busy` high for 13 cycles.
- `len` = 0 → single `done` pulse; `rd_req`/`wr_req` never asserted.
- `len` = 5, `abort` raised in the same cycle as the 3rd `wr_ack` → IDLE next cycle; exactly 2 strobe pairs issued; `remaining` = 3; no `done`.
- With `BLKMOV_FILL_EN`, `fill` = 1, `fill_byte` = 0xA5, `len` = 4 → four writes of 0xA5; 4 `di_inc`; zero `rd_req`; zero SI strobes; `busy` high for 9 cycles.

Source files
------------

// File: rtl/blkmov_seq.sv
// Block-move sequencer: copies len bytes from [SI] to [DI] through a req/ack bus and
// strobes the SI/DI pointer registers. Optional fill mode under `BLKMOV_FILL_EN.
module blkmov_seq #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
`ifdef BLKMOV_FILL_EN
  input  logic             fill,
  input  logic [7:0]       fill_byte,
`endif
  output logic             rd_req,
  input  logic             rd_ack,
  input  logic [7:0]       rd_data,
  output logic             wr_req,
  input  logic             wr_ack,
  output logic [7:0]       wr_data,
  output logic             si_inc,
  output logic             si_dec,
  output logic             di_inc,
  output logic             di_dec,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_STEP  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [7:0]       byte_q, byte_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic             fill_sel;
  logic [7:0]       fill_val;
  logic             step;

`ifdef BLKMOV_FILL_EN
  assign fill_sel = fill;
  assign fill_val = fill_byte;
`else
  assign fill_sel = 1'b0;
  assign fill_val = 8'h00;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    byte_d  = byte_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d  = len;
          dir_d  = dir;
          fill_d = fill_sel;
          if (fill_sel) byte_d = fill_val;
          if (len == '0)    state_d = ST_DONE;
          else if (fill_sel) state_d = ST_WRITE;
          else               state_d = ST_READ;
        end
      end
      ST_READ: begin
        // Abort wins over a same-cycle ack: the byte is dropped.
        if (abort) state_d = ST_IDLE;
        else if (rd_ack) begin
          byte_d  = rd_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort)       state_d = ST_IDLE;
        else if (wr_ack) state_d = ST_STEP;
      end
      ST_STEP: begin
        if (abort) state_d = ST_IDLE;
        else begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = ST_DONE;
          else if (fill_q)        state_d = ST_WRITE;
          else                    state_d = ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      byte_q  <= 8'h00;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      byte_q  <= byte_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  // Outputs decode the state register directly, so clear_n drops them without a clock.
  always_comb begin
    step      = (state_q == ST_STEP) && !abort;
    rd_req    = (state_q == ST_READ);
    wr_req    = (state_q == ST_WRITE);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE) && !abort;
    si_inc    = step && !dir_q && !fill_q;
    si_dec    = step &&  dir_q && !fill_q;
    di_inc    = step && !dir_q;
    di_dec    = step &&  dir_q;
    wr_data   = byte_q;
    remaining = rem_q;
  end

endmodule

// File: tb/tb_blkmov_seq.sv
// Scoreboard bench for blkmov_seq: read bytes are pushed as expected writes and popped
// on each write handshake. Covers fill mode when BLKMOV_FILL_EN is defined.
module tb_blkmov_seq;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        start;
  logic        dir;
  logic [15:0] len;
  logic        abort;
`ifdef BLKMOV_FILL_EN
  logic        fill;
  logic [7:0]  fill_byte;
`endif
  logic        rd_req, rd_ack;
  logic [7:0]  rd_data;
  logic        wr_req, wr_ack;
  logic [7:0]  wr_data;
  logic        si_inc, si_dec, di_inc, di_dec;
  logic        busy, done;
  logic [15:0] remaining;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  blkmov_seq #(.CNT_W(16)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .start     (start),
    .dir       (dir),
    .len       (len),
    .abort     (abort),
`ifdef BLKMOV_FILL_EN
    .fill      (fill),
    .fill_byte (fill_byte),
`endif
    .rd_req    (rd_req),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_ack    (wr_ack),
    .wr_data   (wr_data),
    .si_inc    (si_inc),
    .si_dec    (si_dec),
    .di_inc    (di_inc),
    .di_dec    (di_dec),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, ".reqs"}, int'({rd_req, wr_req}), 0);
    check_eq({tag, ".strobes"}, int'({si_inc, si_dec, di_inc, di_dec}), 0);
    check_eq({tag, ".busy_done"}, int'({busy, done}), 0);
    check_eq({tag, ".remaining"}, int'(remaining), 0);
    check_eq({tag, ".wr_data"}, int'(wr_data), 0);
  endtask

  // rlat/wlat: cycles in READ/WRITE including the ack cycle. abort_wr>0 aborts on that write ack.
  task automatic run_move(input string tag, input int n, input logic d, input int rlat,
                          input int wlat, input int abort_wr, input logic f,
                          input logic [7:0] fb);
    int busy_c = 0, done_c = 0, done_at = 0, rd_c = 0, wr_c = 0, nread = 0;
    int si_i = 0, si_d = 0, di_i = 0, di_d = 0, both_c = 0, rstab = 0, wstab = 0;
    int rwait = 0, wwait = 0, pairs, exp_busy, exp_reads;
    logic fin = 1'b0, prev_rp = 1'b0, prev_wp = 1'b0, prev_ab = 1'b0;
    logic [7:0] prev_wd = 8'h00;
    exp_q.delete();
    @(negedge clk);
    start = 1'b1;
    len   = 16'(n);
    dir   = d;
`ifdef BLKMOV_FILL_EN
    fill      = f;
    fill_byte = fb;
`endif
    if (f) for (int i = 0; i < n; i++) exp_q.push_back(fb);
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk);
      start  = 1'b0;
      rd_ack = 1'b0;
      wr_ack = 1'b0;
      abort  = 1'b0;
      if (cyc == 3 && n >= 2) begin
        start = 1'b1;
        len   = 16'd7;
        dir   = ~d;
      end
      if (!busy) begin
        fin = 1'b1;
        check_eq({tag, ".idle_outs"},
                 int'({rd_req, wr_req, si_inc, si_dec, di_inc, di_dec, done}), 0);
      end else begin
        busy_c++;
        if (done) begin
          done_c++;
          done_at = busy_c;
        end
        si_i += int'(si_inc);
        si_d += int'(si_dec);
        di_i += int'(di_inc);
        di_d += int'(di_dec);
        if ((si_inc && si_dec) || (di_inc && di_dec)) both_c++;
        if (prev_rp && !rd_req && !prev_ab) rstab++;
        if (prev_wp && (!wr_req || wr_data != prev_wd) && !prev_ab) wstab++;
        if (rd_req) begin
          rd_c++;
          rwait++;
          if (rwait >= rlat) begin
            rwait   = 0;
            rd_ack  = 1'b1;
            rd_data = 8'(8'h11 * (nread + 1));
            nread++;
            exp_q.push_back(rd_data);
          end
        end
        if (wr_req) begin
          wwait++;
          if (wwait >= wlat) begin
            wwait  = 0;
            wr_ack = 1'b1;
            wr_c++;
            if (exp_q.size() == 0) check_eq({tag, ".sb_empty"}, 1, 0);
            else check_eq({tag, ".wr_data"}, int'(wr_data), int'(exp_q.pop_front()));
            if (wr_c == abort_wr) abort = 1'b1;
          end
        end
        prev_rp = rd_req && !rd_ack;
        prev_wp = wr_req && !wr_ack;
        prev_wd = wr_data;
        prev_ab = abort;
      end
    end
    start = 1'b0;
    if (!fin) check_eq({tag, ".timeout"}, 1, 0);

    pairs     = (abort_wr > 0) ? abort_wr - 1 : n;
    exp_reads = f ? 0 : ((abort_wr > 0) ? abort_wr : n);
    if (abort_wr > 0)      exp_busy = (abort_wr - 1) * (rlat + wlat + 1) + rlat + wlat;
    else if (n == 0)       exp_busy = 1;
    else if (f)            exp_busy = n * (wlat + 1) + 1;
    else                   exp_busy = n * (rlat + wlat + 1) + 1;
    check_eq({tag, ".busy_cycles"}, busy_c, exp_busy);
    check_eq({tag, ".done_count"}, done_c, (abort_wr > 0) ? 0 : 1);
    if (abort_wr == 0) check_eq({tag, ".done_at"}, done_at, exp_busy);
    check_eq({tag, ".si_inc"}, si_i, (!f && !d) ? pairs : 0);
    check_eq({tag, ".si_dec"}, si_d, (!f && d) ? pairs : 0);
    check_eq({tag, ".di_inc"}, di_i, !d ? pairs : 0);
    check_eq({tag, ".di_dec"}, di_d, d ? pairs : 0);
    check_eq({tag, ".inc_dec_both"}, both_c, 0);
    check_eq({tag, ".rd_req_cycles"}, rd_c, exp_reads * rlat);
    check_eq({tag, ".writes"}, wr_c, (abort_wr > 0) ? abort_wr : n);
    check_eq({tag, ".rd_stable"}, rstab, 0);
    check_eq({tag, ".wr_stable"}, wstab, 0);
    check_eq({tag, ".remaining"}, int'(remaining), (abort_wr > 0) ? n - pairs : 0);
    check_eq({tag, ".sb_left"}, exp_q.size(), 0);
  endtask

  initial begin
    logic saw_wr;
    clear_n = 1'b0;
    start   = 1'b0;
    dir     = 1'b0;
    len     = '0;
    abort   = 1'b0;
    rd_ack  = 1'b0;
    rd_data = 8'h00;
    wr_ack  = 1'b0;
`ifdef BLKMOV_FILL_EN
    fill      = 1'b0;
    fill_byte = 8'h00;
`endif
    #12;
    check_reset("por");
    @(negedge clk);
    clear_n = 1'b1;

    run_move("copy3",  3, 1'b0, 1, 1, 0, 1'b0, 8'h00);
    run_move("desc2",  2, 1'b1, 4, 1, 0, 1'b0, 8'h00);
    run_move("len0",   0, 1'b0, 1, 1, 0, 1'b0, 8'h00);
    run_move("abort5", 5, 1'b0, 1, 1, 3, 1'b0, 8'h00);
    run_move("waits2", 2, 1'b0, 2, 3, 0, 1'b0, 8'h00);
`ifdef BLKMOV_FILL_EN
    run_move("fill4",  4, 1'b0, 1, 1, 0, 1'b1, 8'hA5);
    run_move("filld3", 3, 1'b1, 1, 2, 0, 1'b1, 8'h3C);
`endif

    // Asynchronous clear while a write is pending.
    saw_wr = 1'b0;
    @(negedge clk);
    start = 1'b1;
    len   = 16'd4;
    dir   = 1'b0;
    for (int i = 0; i < 20 && !saw_wr; i++) begin
      @(negedge clk);
      start  = 1'b0;
      rd_ack = rd_req;
      if (wr_req) saw_wr = 1'b1;
    end
    rd_ack = 1'b0;
    check_eq("rst.saw_wr", int'(saw_wr), 1);
    #2;
    clear_n = 1'b0;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    check_reset("rst_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
